// File: rtl/serdes_pkg.sv
// Shared constants and types for the 8b/10b comma aligner.
package serdes_pkg;

    // K28.5 comma in both running-disparity forms
    localparam logic [9:0] COMMA_P_DEF = 10'b0011111010;
    localparam logic [9:0] COMMA_N_DEF = 10'b1100000101;

    // Default lock / unlock thresholds
    localparam int LOCK_CNT_DEF   = 3;
    localparam int UNLOCK_CNT_DEF = 2;

    // Width of the lock and error counters
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2
    } align_state_t;

endpackage

// File: rtl/comma_detect.sv
// Combinational compare of a 10-bit window against both K28.5 forms.
module comma_detect
    import serdes_pkg::*;
#(
    parameter logic [9:0] COMMA_P = COMMA_P_DEF,
    parameter logic [9:0] COMMA_N = COMMA_N_DEF
) (
    input  logic [9:0] word,
    output logic       match
);

    assign match = (word == COMMA_P) || (word == COMMA_N);

endmodule

// File: rtl/deserializer_align.sv
// Serial-to-parallel converter that finds K28.5 commas in the bit stream,
// locks its word boundary onto them and emits aligned 10-bit words.
//
// Output qualifier: valid is a single-cycle strobe with no back-pressure;
// data_out and comma_det are meaningful only in the cycle valid is high,
// and data_out keeps its last value otherwise.
module deserializer_align
    import serdes_pkg::*;
#(
    parameter logic [9:0] COMMA_P    = COMMA_P_DEF,
    parameter logic [9:0] COMMA_N    = COMMA_N_DEF,
    parameter int         LOCK_CNT   = LOCK_CNT_DEF,
    parameter int         UNLOCK_CNT = UNLOCK_CNT_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic         data_in,
    output logic [9:0]   data_out,
    output logic         valid,
    output logic         comma_det,
    output logic         locked,
    output align_state_t state_dbg
);

    localparam logic [CNT_W-1:0] LOCK_LIM   = CNT_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0] UNLOCK_LIM = CNT_W'(UNLOCK_CNT);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    align_state_t     state_q, state_d;
    logic [9:0]       sr_q;
    logic [3:0]       ph_q, ph_d;
    logic [CNT_W-1:0] lcnt_q, lcnt_d, lcnt_inc;
    logic [CNT_W-1:0] ecnt_q, ecnt_d, ecnt_inc;
    logic             match;
    logic             boundary;
    logic             word_ld;

    comma_detect #(
        .COMMA_P(COMMA_P),
        .COMMA_N(COMMA_N)
    ) u_comma_detect (
        .word (sr_q),
        .match(match)
    );

    assign boundary = (ph_q == 4'd0);
    assign lcnt_inc = lcnt_q + CNT_ONE;
    assign ecnt_inc = ecnt_q + CNT_ONE;

    // State register: advances only on enabled edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HUNT;
        end else if (enable) begin
            state_q <= state_d;
        end
    end

    // Next-state, phase and counter updates from the current window
    always_comb begin
        state_d = state_q;
        ph_d    = (ph_q == 4'd9) ? 4'd0 : ph_q + 4'd1;
        lcnt_d  = lcnt_q;
        ecnt_d  = ecnt_q;
        word_ld = 1'b0;
        case (state_q)
            ST_HUNT: begin
                if (match) begin
                    state_d = ST_CONFIRM;
                    ph_d    = 4'd1;
                    lcnt_d  = CNT_ONE;
                end
            end
            ST_CONFIRM: begin
                if (boundary) begin
                    if (match) begin
                        lcnt_d = lcnt_inc;
                        if (lcnt_inc >= LOCK_LIM) begin
                            state_d = ST_LOCKED;
                            word_ld = 1'b1;
                        end
                    end else begin
                        state_d = ST_HUNT;
                        lcnt_d  = '0;
                    end
                end else if (match) begin
                    // Comma seen off-phase: restart confirmation at this phase
                    ph_d   = 4'd1;
                    lcnt_d = CNT_ONE;
                end
            end
            ST_LOCKED: begin
                if (boundary) begin
                    word_ld = 1'b1;
                    if (match) begin
                        ecnt_d = '0;
                    end
                end else if (match) begin
                    ecnt_d = ecnt_inc;
                    if (ecnt_inc >= UNLOCK_LIM) begin
                        state_d = ST_HUNT;
                        ph_d    = 4'd0;
                        lcnt_d  = '0;
                        ecnt_d  = '0;
                    end
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase
    end

    // Shift register, phase, counters and word output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q      <= '0;
            ph_q      <= '0;
            lcnt_q    <= '0;
            ecnt_q    <= '0;
            data_out  <= '0;
            valid     <= 1'b0;
            comma_det <= 1'b0;
        end else begin
            // Strobes drop on every edge that is not an enabled word boundary
            valid     <= enable & word_ld;
            comma_det <= enable & word_ld & match;
            if (enable) begin
                sr_q   <= {sr_q[8:0], data_in};
                ph_q   <= ph_d;
                lcnt_q <= lcnt_d;
                ecnt_q <= ecnt_d;
                if (word_ld) begin
                    data_out <= sr_q;
                end
            end
        end
    end

    // Status outputs decoded from the state register
    always_comb begin
        locked    = (state_q == ST_LOCKED);
        state_dbg = state_q;
    end

endmodule

// File: tb/tb_deserializer_align.sv
// Directed bench for deserializer_align with an expected-word queue.
module tb_deserializer_align;
    import serdes_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic         data_in;
    logic [9:0]   data_out;
    logic         valid;
    logic         comma_det;
    logic         locked;
    align_state_t state_dbg;

    deserializer_align dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .data_in  (data_in),
        .data_out (data_out),
        .valid    (valid),
        .comma_det(comma_det),
        .locked   (locked),
        .state_dbg(state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    int          n_pass    = 0;
    int          n_total   = 0;
    int          cyc       = 0;
    int          last_vcyc = -1;
    int          exp_gap   = 0;
    int          n_valid   = 0;
    logic [10:0] exp_q[$];
    logic [10:0] mon_e;
    logic [9:0]  win;
    logic        rb;
    int          v_start;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Scoreboard: sample just after each rising edge
    always @(posedge clk) begin
        #1;
        cyc++;
        chk("comma_det_without_valid", 32'(comma_det & ~valid), 32'(0));
        if (valid) begin
            n_valid++;
            chk("valid_on_enabled_edge", 32'(enable), 32'(1));
            if (exp_q.size() == 0) begin
                chk("spurious_valid", 32'(valid), 32'(0));
            end else begin
                mon_e = exp_q.pop_front();
                chk("data_out", 32'(data_out), 32'(mon_e[9:0]));
                chk("comma_det", 32'(comma_det), 32'(mon_e[10]));
            end
            if (exp_gap != 0 && last_vcyc >= 0)
                chk("valid_gap", 32'(cyc - last_vcyc), 32'(exp_gap));
            last_vcyc = cyc;
        end
    end

    task automatic drive_bit(input logic b, input bit tog);
        data_in = b;
        enable  = 1'b1;
        @(negedge clk);
        if (tog) begin
            enable  = 1'b0;
            data_in = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
    endtask

    task automatic drive_range(input logic [9:0] w, input int msb, input int lsb, input bit tog);
        for (int i = msb; i >= lsb; i--) drive_bit(w[i], tog);
    endtask

    task automatic drive_word(input logic [9:0] w, input bit tog);
        drive_range(w, 9, 0, tog);
    endtask

    task automatic do_reset();
        enable  = 1'b0;
        data_in = 1'b0;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Three zeros, three commas, then 0x2AA and 0x155; locked is checked around the 34th bit
    task automatic lock_stream(input bit tog, input string tag);
        exp_q.push_back({1'b1, 10'h0FA});
        exp_q.push_back({1'b0, 10'h2AA});
        exp_q.push_back({1'b0, 10'h155});
        drive_range(10'h000, 2, 0, tog);
        repeat (3) drive_word(10'h0FA, tog);
        chk({tag, "_locked_before"}, 32'(locked), 32'(0));
        drive_range(10'h2AA, 9, 9, tog);
        chk({tag, "_locked_rise"}, 32'(locked), 32'(1));
        chk({tag, "_state_locked"}, 32'(state_dbg), 32'(ST_LOCKED));
        drive_range(10'h2AA, 8, 8, tog);
        chk({tag, "_data_hold"}, 32'(data_out), 32'(10'h0FA));
        drive_range(10'h2AA, 7, 0, tog);
        drive_word(10'h155, tog);
    endtask

    initial begin
        rst_n   = 1'b0;
        enable  = 1'b0;
        data_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_data_out", 32'(data_out), 32'(0));
        chk("reset_valid", 32'(valid), 32'(0));
        chk("reset_comma_det", 32'(comma_det), 32'(0));
        chk("reset_locked", 32'(locked), 32'(0));
        chk("reset_state", 32'(state_dbg), 32'(ST_HUNT));
        rst_n = 1'b1;

        // Random stream with no comma at any offset
        win = '0;
        for (int i = 0; i < 60; i++) begin
            rb = 1'($urandom_range(0, 1));
            if ({win[8:0], rb} == COMMA_P_DEF || {win[8:0], rb} == COMMA_N_DEF) rb = ~rb;
            win = {win[8:0], rb};
            drive_bit(rb, 1'b0);
        end
        chk("nocomma_locked", 32'(locked), 32'(0));
        chk("nocomma_state", 32'(state_dbg), 32'(ST_HUNT));
        chk("nocomma_valid_count", 32'(n_valid), 32'(0));

        // Lock with continuous enable
        do_reset();
        last_vcyc = -1;
        exp_gap   = 10;
        lock_stream(1'b0, "cont");

        // One slipped bit, then 0x305 commas at the new phase
        exp_q.push_back({1'b0, 10'h182});
        exp_q.push_back({1'b0, 10'h382});
        exp_q.push_back({1'b1, 10'h0FA});
        exp_q.push_back({1'b0, 10'h123});
        exp_q.push_back({1'b0, 10'h2C7});
        drive_bit(1'b0, 1'b0);
        drive_word(10'h305, 1'b0);
        drive_word(10'h305, 1'b0);
        exp_gap = 0;
        chk("slip_locked_held", 32'(locked), 32'(1));
        drive_range(10'h305, 9, 9, 1'b0);
        chk("slip_locked_drop", 32'(locked), 32'(0));
        chk("slip_state_hunt", 32'(state_dbg), 32'(ST_HUNT));
        chk("slip_data_hold", 32'(data_out), 32'(10'h382));
        drive_range(10'h305, 8, 0, 1'b0);
        drive_word(10'h305, 1'b0);
        drive_word(10'h0FA, 1'b0);
        chk("relock_before", 32'(locked), 32'(0));
        last_vcyc = -1;
        exp_gap   = 10;
        drive_range(10'h123, 9, 9, 1'b0);
        chk("relock_rise", 32'(locked), 32'(1));
        drive_range(10'h123, 8, 0, 1'b0);
        drive_word(10'h2C7, 1'b0);
        drive_range(10'h000, 4, 0, 1'b0);
        enable = 1'b0;
        chk("slip_queue_empty", 32'(exp_q.size()), 32'(0));

        // Same lock stream with enable toggling every cycle
        do_reset();
        last_vcyc = -1;
        exp_gap   = 20;
        v_start   = n_valid;
        lock_stream(1'b1, "tog");
        drive_range(10'h000, 4, 0, 1'b1);
        enable = 1'b0;
        chk("tog_valid_count", 32'(n_valid - v_start), 32'(3));
        chk("tog_queue_empty", 32'(exp_q.size()), 32'(0));
        chk("tog_last_word", 32'(data_out), 32'(10'h155));

        // Asynchronous reset mid-word while locked
        do_reset();
        last_vcyc = -1;
        exp_gap   = 10;
        exp_q.push_back({1'b1, 10'h0FA});
        exp_q.push_back({1'b0, 10'h2AA});
        drive_range(10'h000, 2, 0, 1'b0);
        repeat (3) drive_word(10'h0FA, 1'b0);
        drive_word(10'h2AA, 1'b0);
        drive_range(10'h155, 9, 5, 1'b0);
        chk("midword_locked_pre", 32'(locked), 32'(1));
        chk("midword_queue_empty", 32'(exp_q.size()), 32'(0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_data_out", 32'(data_out), 32'(0));
        chk("async_rst_valid", 32'(valid), 32'(0));
        chk("async_rst_comma_det", 32'(comma_det), 32'(0));
        chk("async_rst_locked", 32'(locked), 32'(0));
        chk("async_rst_state", 32'(state_dbg), 32'(ST_HUNT));
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        last_vcyc = -1;
        lock_stream(1'b0, "rst_relock");
        drive_range(10'h000, 4, 0, 1'b0);
        enable = 1'b0;
        chk("rst_relock_queue_empty", 32'(exp_q.size()), 32'(0));
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
